bcla_add_scheduler: RTL and testbench

//  Shares one combinational 29b+29b->30b block carry look-ahead adder core (unsigned, carry-in 0) among

---
 rtl/bcla_sched_pkg.sv | 23 ++
 rtl/bcla_add_scheduler_adder.sv | 49 ++++
 rtl/bcla_add_scheduler_rr_arbiter.sv | 64 ++++++
 rtl/bcla_add_scheduler.sv | 121 ++++++++++++
 tb/tb_bcla_add_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcla_sched_pkg.sv
// Shared constants, operand/sum types and a width helper for the shared-adder scheduler.
package bcla_sched_pkg;

    localparam int OPW  = 29;
    localparam int SUMW = OPW + 1;
    localparam int BLKW = 4;
    localparam int NBLK = (OPW + BLKW - 1) / BLKW;

    typedef logic [OPW-1:0]  op_t;
    typedef logic [SUMW-1:0] sum_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcla_add_scheduler_adder.sv
// Block carry look-ahead adder: 4-bit blocks, carry-in 0, carry-out lands in sum[OPW].
module bcla_adder
    import bcla_sched_pkg::*;
(
    input  logic [OPW-1:0]  x,
    input  logic [OPW-1:0]  y,
    output logic [SUMW-1:0] sum
);

    logic [OPW-1:0] g;
    logic [OPW-1:0] p;
    logic [NBLK:0]  c_blk;

    assign g        = x & y;
    assign p        = x ^ y;
    assign c_blk[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
            localparam int LO = gi * BLKW;
            // The top block is narrower when OPW is not a multiple of the block width.
            localparam int W  = ((OPW - LO) < BLKW) ? (OPW - LO) : BLKW;

            logic [W-1:0] c;
            logic         blk_g;
            logic         blk_p;

            always_comb begin
                blk_g = 1'b0;
                blk_p = 1'b1;
                for (int j = 0; j < W; j++) begin
                    blk_g = g[LO+j] | (p[LO+j] & blk_g);
                    blk_p = blk_p & p[LO+j];
                end
            end

            assign c[0] = c_blk[gi];
            for (genvar gj = 1; gj < W; gj++) begin : g_bit
                assign c[gj] = g[LO+gj-1] | (p[LO+gj-1] & c[gj-1]);
            end

            assign c_blk[gi+1]  = blk_g | (blk_p & c_blk[gi]);
            assign sum[LO +: W] = p[LO +: W] ^ c;
        end
    endgenerate

    assign sum[OPW] = c_blk[NBLK];

endmodule

// File: rtl/bcla_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on a grant.
module rr_arbiter
    import bcla_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] win;
    logic           found;
    int             j;

    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    assign gnt_any = en && found;
    assign gnt_idx = win;

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bcla_add_scheduler.sv
// Shares one BCLA adder among NREQ requesters: RR grant -> operand stage A -> result stage B.
module bcla_add_scheduler
    import bcla_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_x,
    input  logic [NREQ*OPW-1:0] req_y,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [SUMW-1:0]     res_sum,
    output logic                busy
);

    op_t      x_arr [NREQ];
    op_t      y_arr [NREQ];

    logic     adv_a;
    logic     adv_b;
    logic     gnt_any;
    logic [IDW-1:0] gnt_idx;
    sum_t     sum_a;

    logic     va_q, va_d;
    logic     vb_q, vb_d;
    logic [IDW-1:0] id_a_q, id_a_d;
    op_t      x_a_q, x_a_d;
    op_t      y_a_q, y_a_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    sum_t     res_sum_q, res_sum_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*OPW +: OPW];
            assign y_arr[gi] = req_y[gi*OPW +: OPW];
        end
    endgenerate

    assign adv_b = !vb_q || res_ready;
    assign adv_a = !va_q || adv_b;

    // Grants are masked during reset so req_ready reads zero while rst is high.
    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (adv_a && !rst),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    bcla_adder u_adder (
        .x   (x_a_q),
        .y   (y_a_q),
        .sum (sum_a)
    );

    always_comb begin
        va_d   = va_q;
        id_a_d = id_a_q;
        x_a_d  = x_a_q;
        y_a_d  = y_a_q;
        if (adv_a) begin
            va_d = gnt_any;
            if (gnt_any) begin
                id_a_d = gnt_idx;
                x_a_d  = x_arr[gnt_idx];
                y_a_d  = y_arr[gnt_idx];
            end
        end
    end

    always_comb begin
        vb_d      = vb_q;
        res_id_d  = res_id_q;
        res_sum_d = res_sum_q;
        if (adv_b) begin
            vb_d = va_q;
            if (va_q) begin
                res_id_d  = id_a_q;
                res_sum_d = sum_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q      <= 1'b0;
            vb_q      <= 1'b0;
            id_a_q    <= '0;
            x_a_q     <= '0;
            y_a_q     <= '0;
            res_id_q  <= '0;
            res_sum_q <= '0;
        end else begin
            va_q      <= va_d;
            vb_q      <= vb_d;
            id_a_q    <= id_a_d;
            x_a_q     <= x_a_d;
            y_a_q     <= y_a_d;
            res_id_q  <= res_id_d;
            res_sum_q <= res_sum_d;
        end
    end

    assign res_valid = vb_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign busy      = va_q || vb_q;

endmodule

// File: tb/tb_bcla_add_scheduler.sv
// Bench for the shared-adder scheduler: vector table, directed corner sequences, random scoreboard.
module tb_bcla_add_scheduler;
    import bcla_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_x;
    logic [NREQ*OPW-1:0] req_y;
    logic                res_valid;
    logic                res_ready;
    logic [IDW-1:0]      res_id;
    logic [SUMW-1:0]     res_sum;
    logic                busy;

    bcla_add_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   id;
        op_t  x;
        op_t  y;
        sum_t exp;
    } vec_t;

    typedef struct {
        int   id;
        sum_t sum;
        int   t;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    logic [NREQ-1:0] hold = '0;
    op_t  pend_x [NREQ];
    op_t  pend_y [NREQ];
    exp_t q [$];
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic sum_t ref_add(input op_t x, input op_t y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic op_t rand_op();
        if ($urandom_range(0, 3) == 0) return 29'h1FFFFFFF;
        return op_t'($urandom);
    endfunction

    task automatic set_op(input int i, input op_t x, input op_t y);
        req_x[i*OPW +: OPW] = x;
        req_y[i*OPW +: OPW] = y;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_clear();
        q.delete();
        hold  = '0;
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend_x[i] = rand_op();
            pend_y[i] = rand_op();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    // One cycle against the reference: in-flight ops are a FIFO, each delivered no sooner than 2 cycles
    // after acceptance; a new grant is possible unless two ops are in flight and the output is stalled.
    task automatic sb_cycle(input logic [NREQ-1:0] mask, input logic rr, output int g, output logic [NREQ-1:0] rdy);
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        int              w;
        int              jj;
        exp_rv = (q.size() > 0) && (q[0].t + 2 <= cyc);
        chk("res_valid", res_valid, exp_rv);
        if (res_valid && q.size() > 0) begin
            chk("res_id", res_id, q[0].id);
            chk("res_sum", res_sum, q[0].sum);
        end
        v         = mask | hold;
        req_valid = v;
        res_ready = rr;
        for (int i = 0; i < NREQ; i++) set_op(i, pend_x[i], pend_y[i]);
        #1;
        w = -1;
        if (v != 0 && (q.size() < 2 || rr)) begin
            for (int k = 0; k < NREQ; k++) begin
                jj = (m_ptr + k) % NREQ;
                if (w < 0 && v[jj]) w = jj;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        rdy = req_ready;
        g   = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (g < 0 && v[i] && req_ready[i]) g = i;
        end
        if (res_valid && rr && q.size() > 0) void'(q.pop_front());
        hold = v;
        if (g >= 0) begin
            q.push_back('{g, ref_add(pend_x[g], pend_y[g]), cyc});
            pend_x[g] = rand_op();
            pend_y[g] = rand_op();
            m_ptr     = (g + 1) % NREQ;
            hold[g]   = 1'b0;
        end
        tick();
    endtask

    task automatic drain();
        int              n;
        int              g;
        logic [NREQ-1:0] rdy;
        n = 0;
        while ((q.size() > 0 || hold != 0 || busy) && n < 60) begin
            sb_cycle('0, 1'b1, g, rdy);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int              g;
        int              cnt [NREQ];
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] oh;
        sum_t            snap_sum;
        logic [IDW-1:0]  snap_id;

        vecs[0] = '{1, 29'h0000005, 29'h0000003, 30'h00000008};
        vecs[1] = '{0, 29'h1FFFFFFF, 29'h1FFFFFFF, 30'h3FFFFFFE};
        vecs[2] = '{3, 29'h1FFFFFFF, 29'h0000001, 30'h20000000};
        vecs[3] = '{2, 29'h0000000, 29'h0000000, 30'h00000000};
        vecs[4] = '{1, 29'h15555555, 29'h0AAAAAAA, 30'h1FFFFFFF};
        vecs[5] = '{3, 29'h0000FFF, 29'h0000001, 30'h00001000};

        // Reset held 3 cycles with every requester valid.
        rst       = 1'b1;
        res_ready = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        model_clear();
        for (int i = 0; i < NREQ; i++) set_op(i, pend_x[i], pend_y[i]);
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_sum", res_sum, 0);
        rst = 1'b0;
        sb_cycle('1, 1'b1, g, rdy);
        chk("first_grant", g, 0);
        drain();

        // Table of single ops: exact 2-cycle latency and busy window.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            oh = '0;
            oh[vecs[t].id] = 1'b1;
            req_valid = oh;
            set_op(vecs[t].id, vecs[t].x, vecs[t].y);
            res_ready = 1'b1;
            #1;
            chk("tbl_ready", req_ready, oh);
            tick();
            req_valid = '0;
            chk("tbl_t1_valid", res_valid, 0);
            chk("tbl_t1_busy", busy, 1);
            tick();
            chk("tbl_t2_valid", res_valid, 1);
            chk("tbl_t2_id", res_id, vecs[t].id);
            chk("tbl_t2_sum", res_sum, vecs[t].exp);
            chk("tbl_t2_busy", busy, 1);
            tick();
            chk("tbl_t3_valid", res_valid, 0);
            chk("tbl_t3_busy", busy, 0);
        end

        // Fairness: all requesters valid for 16 cycles.
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            sb_cycle('1, 1'b1, g, rdy);
            chk("fair_order", g, c % NREQ);
            if (g >= 0) cnt[g]++;
        end
        for (int i = 0; i < NREQ; i++) chk("fair_count", cnt[i], 4);
        drain();

        // Backpressure: stream from requester 2, output stalled for 5 cycles.
        do_reset();
        snap_sum = '0;
        snap_id  = '0;
        for (int c = 0; c < 20; c++) begin
            if (c == 6) begin
                chk("bp_full", res_valid, 1);
                snap_sum = res_sum;
                snap_id  = res_id;
            end
            if (c >= 7 && c <= 10) begin
                chk("bp_hold_valid", res_valid, 1);
                chk("bp_hold_sum", res_sum, snap_sum);
                chk("bp_hold_id", res_id, snap_id);
            end
            sb_cycle(4'b0100, !(c >= 6 && c <= 10), g, rdy);
            if (c >= 7 && c <= 10) chk("bp_ready", rdy, 0);
        end
        drain();

        // Reset with both stages full.
        do_reset();
        repeat (3) sb_cycle('1, 1'b0, g, rdy);
        chk("mid_busy_pre", busy, 1);
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        chk("mid_res_valid", res_valid, 0);
        chk("mid_busy", busy, 0);
        model_clear();
        sb_cycle('1, 1'b1, g, rdy);
        chk("mid_ptr_grant", g, 0);
        drain();

        // Random traffic against the reference.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            sb_cycle(NREQ'($urandom), ($urandom_range(0, 3) != 0), g, rdy);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
